// File: rtl/dsa_pkg.sv
// Shared DSA definitions: memory-map addresses, STATUS layout and the result-bus FSM states.
package dsa_pkg;

    // Operand feeder addresses; this block does not decode them, so they read back as 0 here.
    localparam logic [31:0] DSA_ADDR_OPA     = 32'hC400_0004;
    localparam logic [31:0] DSA_ADDR_OPB     = 32'hC400_0008;
    localparam logic [31:0] DSA_ADDR_OPCTRL  = 32'hC400_000C;

    localparam logic [31:0] DSA_ADDR_RESULT  = 32'hC400_0000;
    localparam logic [31:0] DSA_ADDR_STATUS  = 32'hC400_0010;
    localparam logic [31:0] DSA_ADDR_CTRL    = 32'hC400_0014;
    localparam logic [31:0] DSA_ADDR_DROPCNT = 32'hC400_0018;

    localparam int ST_EMPTY_BIT = 0;
    localparam int ST_FULL_BIT  = 1;
    localparam int ST_OVF_BIT   = 2;
    localparam int ST_CNT_LSB   = 8;
    localparam int ST_CNT_W     = 8;

    localparam int CTRL_FLUSH_BIT = 0;
    localparam int DROPCNT_W      = 16;

    typedef enum logic [1:0] {
        BUS_IDLE = 2'd0,
        BUS_WAIT = 2'd1,
        BUS_RESP = 2'd2
    } bus_state_e;

endpackage

// File: rtl/rbuf_fifo.sv
// Synchronous result FIFO; flush dominates push and pop, push is ignored when full.
module rbuf_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [W-1:0]             data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [W-1:0]             head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][W-1:0] mem;
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic [AW:0]             count_q;
    logic                    push_ok, pop_ok;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o && !flush_i;
    assign pop_ok  = pop_i && !empty_o && !flush_i;
    assign head_o  = mem[rd_ptr];
    assign count_o = count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; entries are only observable once counted.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr] <= data_i;
    end

endmodule

// File: rtl/dsa_result_buffer.sv
// DSA result buffer: FIFO of FP results behind a memory-mapped RESULT/STATUS/CTRL/DROPCNT port.
// Optional DROPCNT register is built when DSA_RBUF_DROPCNT_EN is defined.
module dsa_result_buffer
    import dsa_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            S_DEVICE_strobe_i,
    input  logic [XLEN-1:0] S_DEVICE_addr_i,
    input  logic            S_DEVICE_rw_i,
    input  logic [XLEN-1:0] S_DEVICE_data_i,
    output logic            S_R_DEVICE_ready_o,
    output logic [XLEN-1:0] S_R_DEVICE_data_o,
    input  logic            r_valid_i,
    input  logic [XLEN-1:0] r_data_i,
    output logic            full_o,
    output logic            empty_o
);
    localparam int AW = $clog2(DEPTH);

    bus_state_e      state_q, state_d;
    logic            fifo_full, fifo_empty;
    logic [AW:0]     fifo_count;
    logic [XLEN-1:0] fifo_head;
    logic            idle_strobe, is_result, is_status, is_ctrl;
    logic            pop, flush, drop, load_rdata, ovf_q;
    logic [XLEN-1:0] rdata_d, rdata_q, status_word, reg_rdata;
    logic            unused_wdata;

    assign unused_wdata = ^S_DEVICE_data_i[XLEN-1:1];

    assign idle_strobe = (state_q == BUS_IDLE) && S_DEVICE_strobe_i;
    assign is_result   = (S_DEVICE_addr_i == XLEN'(DSA_ADDR_RESULT));
    assign is_status   = (S_DEVICE_addr_i == XLEN'(DSA_ADDR_STATUS));
    assign is_ctrl     = (S_DEVICE_addr_i == XLEN'(DSA_ADDR_CTRL));
    assign flush       = idle_strobe && S_DEVICE_rw_i && is_ctrl && S_DEVICE_data_i[CTRL_FLUSH_BIT];
    // A push coinciding with a flush is discarded silently, not counted as a drop.
    assign drop        = r_valid_i && fifo_full && !flush;

    rbuf_fifo #(.W(XLEN), .DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (r_valid_i),
        .data_i  (r_data_i),
        .pop_i   (pop),
        .flush_i (flush),
        .head_o  (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign full_o  = fifo_full;
    assign empty_o = fifo_empty;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) ovf_q <= 1'b0;
        else if (flush) ovf_q <= 1'b0;
        else if (drop) ovf_q <= 1'b1;
    end

`ifdef DSA_RBUF_DROPCNT_EN
    logic [DROPCNT_W-1:0] dropcnt_q;
    logic                 is_dropcnt;

    assign is_dropcnt = (S_DEVICE_addr_i == XLEN'(DSA_ADDR_DROPCNT));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) dropcnt_q <= '0;
        else if (flush) dropcnt_q <= '0;
        else if (drop && (dropcnt_q != '1)) dropcnt_q <= dropcnt_q + DROPCNT_W'(1);
    end
`endif

    always_comb begin
        status_word = '0;
        status_word[ST_EMPTY_BIT] = fifo_empty;
        status_word[ST_FULL_BIT]  = fifo_full;
        status_word[ST_OVF_BIT]   = ovf_q;
        status_word[ST_CNT_LSB +: ST_CNT_W] = ST_CNT_W'(fifo_count);
    end

    always_comb begin
        reg_rdata = '0;
        if (is_status) reg_rdata = status_word;
`ifdef DSA_RBUF_DROPCNT_EN
        else if (is_dropcnt) reg_rdata = XLEN'(dropcnt_q);
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= BUS_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BUS_IDLE: if (S_DEVICE_strobe_i) begin
                if (!S_DEVICE_rw_i && is_result && fifo_empty) state_d = BUS_WAIT;
                else                                           state_d = BUS_RESP;
            end
            BUS_WAIT: if (!fifo_empty) state_d = BUS_RESP;
            BUS_RESP: state_d = BUS_IDLE;
            default:  state_d = BUS_IDLE;
        endcase
    end

    always_comb begin
        pop        = 1'b0;
        load_rdata = 1'b0;
        rdata_d    = '0;
        case (state_q)
            BUS_IDLE: if (idle_strobe) begin
                if (!S_DEVICE_rw_i && is_result) begin
                    pop        = !fifo_empty;
                    load_rdata = !fifo_empty;
                    rdata_d    = fifo_head;
                end else begin
                    load_rdata = 1'b1;
                    rdata_d    = S_DEVICE_rw_i ? '0 : reg_rdata;
                end
            end
            BUS_WAIT: begin
                pop        = !fifo_empty;
                load_rdata = !fifo_empty;
                rdata_d    = fifo_head;
            end
            default: ;
        endcase
    end

    assign S_R_DEVICE_ready_o = (state_q == BUS_RESP);

    // Read data holds between responses so software may sample it late.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)           rdata_q <= '0;
        else if (load_rdata) rdata_q <= rdata_d;
    end

    assign S_R_DEVICE_data_o = rdata_q;

endmodule

// File: tb/tb_dsa_result_buffer.sv
// Directed self-checking bench for dsa_result_buffer (DEPTH=8, XLEN=32).
module tb_dsa_result_buffer;
    localparam logic [31:0] A_RESULT  = 32'hC400_0000;
    localparam logic [31:0] A_STATUS  = 32'hC400_0010;
    localparam logic [31:0] A_CTRL    = 32'hC400_0014;
    localparam logic [31:0] A_DROPCNT = 32'hC400_0018;
    localparam logic [31:0] A_UNMAP   = 32'hC400_0020;

    logic        clk = 1'b0;
    logic        rst, strobe, rw, ready, r_valid, full, empty;
    logic [31:0] addr, wdata, rdata, r_data;
    int          tests = 0;
    int          fails = 0;

    dsa_result_buffer #(.XLEN(32), .DEPTH(8)) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .S_DEVICE_strobe_i  (strobe),
        .S_DEVICE_addr_i    (addr),
        .S_DEVICE_rw_i      (rw),
        .S_DEVICE_data_i    (wdata),
        .S_R_DEVICE_ready_o (ready),
        .S_R_DEVICE_data_o  (rdata),
        .r_valid_i          (r_valid),
        .r_data_i           (r_data),
        .full_o             (full),
        .empty_o            (empty)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic push(input logic [31:0] d);
        r_valid = 1'b1; r_data = d;
        tick();
        r_valid = 1'b0;
    endtask

    // Issues one strobe; returns ready/data seen in the following cycle, then lets RESP retire.
    task automatic bus_op(input logic [31:0] a, input logic w, input logic [31:0] d,
                          output logic rdy, output logic [31:0] q);
        strobe = 1'b1; addr = a; rw = w; wdata = d;
        tick();
        strobe = 1'b0; rw = 1'b0;
        rdy = ready; q = rdata;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; strobe = 1'b0; rw = 1'b0; addr = '0; wdata = '0; r_valid = 1'b0; r_data = '0;
        tick(); tick();
        tests++; if (ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %b exp 0", ready); end
        tests++; if (rdata !== 32'h0) begin fails++; $display("FAIL reset_data got %h exp 00000000", rdata); end
        tests++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full got %b exp 0", full); end
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL reset_empty got %b exp 1", empty); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fifo_order();
        logic [31:0] exp_v [3];
        logic        rdy;
        logic [31:0] q;
        exp_v = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000};
        for (int i = 0; i < 3; i++) push(exp_v[i]);
        tests++; if (empty !== 1'b0) begin fails++; $display("FAIL order_nonempty got %b exp 0", empty); end
        for (int i = 0; i < 3; i++) begin
            strobe = 1'b1; addr = A_RESULT; rw = 1'b0;
            tick();
            strobe = 1'b0;
            tests++; if (ready !== 1'b1) begin fails++; $display("FAIL order_ready%0d got %b exp 1", i, ready); end
            tests++; if (rdata !== exp_v[i]) begin fails++; $display("FAIL order_data%0d got %h exp %h", i, rdata, exp_v[i]); end
            tick();
            tests++; if (ready !== 1'b0) begin fails++; $display("FAIL order_ready_pulse%0d got %b exp 0", i, ready); end
            tests++; if (rdata !== exp_v[i]) begin fails++; $display("FAIL order_hold%0d got %h exp %h", i, rdata, exp_v[i]); end
        end
        bus_op(A_STATUS, 1'b0, '0, rdy, q);
        tests++; if (rdy !== 1'b1 || q !== 32'h0000_0001) begin fails++; $display("FAIL order_status got rdy=%b %h exp rdy=1 00000001", rdy, q); end
        bus_op(A_UNMAP, 1'b0, '0, rdy, q);
        tests++; if (rdy !== 1'b1 || q !== 32'h0) begin fails++; $display("FAIL unmapped_read got rdy=%b %h exp rdy=1 00000000", rdy, q); end
    endtask

    task automatic test_read_miss();
        int          early = 0;
        logic        rdy;
        logic [31:0] q;
        strobe = 1'b1; addr = A_RESULT; rw = 1'b0;
        tick();
        strobe = 1'b0;
        repeat (4) begin
            if (ready) early++;
            tick();
        end
        r_valid = 1'b1; r_data = 32'h4120_0000;
        if (ready) early++;
        tick();
        r_valid = 1'b0;
        if (ready) early++;
        tests++; if (early != 0) begin fails++; $display("FAIL miss_early_ready got %0d exp 0", early); end
        tick();
        tests++; if (ready !== 1'b1) begin fails++; $display("FAIL miss_ready got %b exp 1", ready); end
        tests++; if (rdata !== 32'h4120_0000) begin fails++; $display("FAIL miss_data got %h exp 41200000", rdata); end
        tick();
        tests++; if (ready !== 1'b0) begin fails++; $display("FAIL miss_ready_pulse got %b exp 0", ready); end
        bus_op(A_STATUS, 1'b0, '0, rdy, q);
        tests++; if (q !== 32'h0000_0001) begin fails++; $display("FAIL miss_status got %h exp 00000001", q); end
    endtask

    task automatic test_overflow();
        logic        rdy;
        logic [31:0] q;
        logic [31:0] exp_drop;
`ifdef DSA_RBUF_DROPCNT_EN
        exp_drop = 32'd2;
`else
        exp_drop = 32'd0;
`endif
        for (int i = 0; i < 10; i++) push(32'h1000_0000 + i);
        tests++; if (full !== 1'b1) begin fails++; $display("FAIL ovf_full got %b exp 1", full); end
        bus_op(A_STATUS, 1'b0, '0, rdy, q);
        tests++; if (q !== 32'h0000_0806) begin fails++; $display("FAIL ovf_status got %h exp 00000806", q); end
        bus_op(A_DROPCNT, 1'b0, '0, rdy, q);
        tests++; if (q !== exp_drop) begin fails++; $display("FAIL ovf_dropcnt got %h exp %h", q, exp_drop); end
        bus_op(A_CTRL, 1'b1, 32'h1, rdy, q);
        tests++; if (rdy !== 1'b1) begin fails++; $display("FAIL ctrl_ready got %b exp 1", rdy); end
        tests++; if (empty !== 1'b1 || full !== 1'b0) begin fails++; $display("FAIL flush_flags got e=%b f=%b exp e=1 f=0", empty, full); end
        bus_op(A_STATUS, 1'b0, '0, rdy, q);
        tests++; if (q !== 32'h0000_0001) begin fails++; $display("FAIL flush_status got %h exp 00000001", q); end
        bus_op(A_DROPCNT, 1'b0, '0, rdy, q);
        tests++; if (q !== 32'h0) begin fails++; $display("FAIL flush_dropcnt got %h exp 00000000", q); end
        // Flush racing a push: the pushed value must vanish with no drop recorded.
        push(32'hAAAA_0001);
        push(32'hAAAA_0002);
        strobe = 1'b1; addr = A_CTRL; rw = 1'b1; wdata = 32'h1;
        r_valid = 1'b1; r_data = 32'hAAAA_0003;
        tick();
        strobe = 1'b0; rw = 1'b0; r_valid = 1'b0;
        tick();
        bus_op(A_STATUS, 1'b0, '0, rdy, q);
        tests++; if (q !== 32'h0000_0001) begin fails++; $display("FAIL flush_push_status got %h exp 00000001", q); end
        bus_op(A_DROPCNT, 1'b0, '0, rdy, q);
        tests++; if (q !== 32'h0) begin fails++; $display("FAIL flush_push_dropcnt got %h exp 00000000", q); end
    endtask

    task automatic test_push_pop_same();
        logic        rdy;
        logic [31:0] q;
        logic [31:0] exp_v [4];
        exp_v = '{32'hB000_0001, 32'hB000_0002, 32'hB000_0003, 32'hB000_0004};
        for (int i = 0; i < 3; i++) push(exp_v[i]);
        strobe = 1'b1; addr = A_RESULT; rw = 1'b0;
        r_valid = 1'b1; r_data = exp_v[3];
        tick();
        strobe = 1'b0; r_valid = 1'b0;
        tests++; if (ready !== 1'b1 || rdata !== exp_v[0]) begin fails++; $display("FAIL pp_first got rdy=%b %h exp rdy=1 %h", ready, rdata, exp_v[0]); end
        tick();
        bus_op(A_STATUS, 1'b0, '0, rdy, q);
        tests++; if (q !== 32'h0000_0300) begin fails++; $display("FAIL pp_status got %h exp 00000300", q); end
        for (int i = 1; i < 4; i++) begin
            bus_op(A_RESULT, 1'b0, '0, rdy, q);
            tests++; if (rdy !== 1'b1 || q !== exp_v[i]) begin fails++; $display("FAIL pp_data%0d got rdy=%b %h exp rdy=1 %h", i, rdy, q, exp_v[i]); end
        end
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL pp_empty got %b exp 1", empty); end
    endtask

    task automatic test_reset_in_wait();
        int          late = 0;
        logic        rdy;
        logic [31:0] q;
        strobe = 1'b1; addr = A_RESULT; rw = 1'b0;
        tick();
        strobe = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        tests++; if (ready !== 1'b0) begin fails++; $display("FAIL rstwait_ready got %b exp 0", ready); end
        tick(); tick();
        rst = 1'b0;
        tick();
        push(32'h4228_0000);
        // An FSM left in WAIT would pop and answer within these two cycles.
        if (ready) late++;
        tick();
        if (ready) late++;
        tick();
        if (ready) late++;
        tests++; if (late != 0) begin fails++; $display("FAIL rstwait_spurious got %0d exp 0", late); end
        bus_op(A_STATUS, 1'b0, '0, rdy, q);
        tests++; if (q !== 32'h0000_0100) begin fails++; $display("FAIL rstwait_status got %h exp 00000100", q); end
        bus_op(A_RESULT, 1'b0, '0, rdy, q);
        tests++; if (rdy !== 1'b1 || q !== 32'h4228_0000) begin fails++; $display("FAIL rstwait_read got rdy=%b %h exp rdy=1 42280000", rdy, q); end
    endtask

    initial begin
        test_reset();
        test_fifo_order();
        test_read_miss();
        test_overflow();
        test_push_pop_same();
        test_reset_in_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "bench did not complete");
    end

endmodule
